// File: rtl/sync_fifo_wr_arbiter.sv
// rtl/sync_fifo_wr_arbiter.sv - round-robin write-port arbiter for a shared sync FIFO with mirrored level.
// Optional per-owner burst mode is enabled by defining FIFO_ARB_BURST_EN.
module sync_fifo_wr_arbiter #(
   parameter int N         = 4,
   parameter int B         = 16,
   parameter int W         = 4,
   parameter int MAXBURST  = 4,
   parameter int AF_MARGIN = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req,
   input  logic [N*B-1:0] data_in,
   output logic [N-1:0]   ack,
   output logic           fifo_wr,
   output logic [B-1:0]   fifo_wdata,
   input  logic           fifo_full,
   input  logic           fifo_rd,
   input  logic           fifo_empty,
   output logic [W:0]     level,
   output logic           almost_full
);

   localparam int PW    = (N > 1) ? $clog2(N) : 1;
   localparam int DEPTH = 1 << W;

   logic [PW-1:0] rr_ptr;
   logic [PW:0]   scan;
   logic          rr_valid;
   logic [PW-1:0] rr_idx;
   logic          win_valid;
   logic [PW-1:0] win_idx;
   logic          wr_acc;
   logic          rd_acc;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      next_ptr = (p == PW'(N - 1)) ? '0 : p + 1'b1;
   endfunction

   // Scan from rr_ptr upward, wrapping at N; the first requester found wins.
   always_comb begin
      rr_valid = 1'b0;
      rr_idx   = '0;
      scan     = '0;
      for (int k = 0; k < N; k++) begin
         scan = {1'b0, rr_ptr} + (PW + 1)'(k);
         if (scan >= (PW + 1)'(N))
            scan = scan - (PW + 1)'(N);
         if (!rr_valid && req[scan[PW-1:0]]) begin
            rr_valid = 1'b1;
            rr_idx   = scan[PW-1:0];
         end
      end
   end

`ifdef FIFO_ARB_BURST_EN
   typedef enum logic {IDLE, BURST} state_t;

   state_t        state;
   logic [PW-1:0] owner;
   logic [3:0]    burst_cnt;

   // While bursting only the owner may win; everyone else waits.
   always_comb begin
      if (state == BURST) begin
         win_valid = req[owner];
         win_idx   = owner;
      end else begin
         win_valid = rr_valid;
         win_idx   = rr_idx;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr    <= '0;
         state     <= IDLE;
         owner     <= '0;
         burst_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (fifo_wr) begin
                  owner     <= win_idx;
                  burst_cnt <= 4'd1;
                  if (MAXBURST > 1)
                     state <= BURST;
                  else
                     rr_ptr <= next_ptr(win_idx);
               end
            end
            BURST: begin
               if (fifo_wr) begin
                  burst_cnt <= burst_cnt + 4'd1;
                  if (burst_cnt + 4'd1 == 4'(MAXBURST)) begin
                     rr_ptr <= next_ptr(owner);
                     state  <= IDLE;
                  end
               end else if (!req[owner]) begin
                  rr_ptr <= next_ptr(owner);
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
`else
   assign win_valid = rr_valid;
   assign win_idx   = rr_idx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rr_ptr <= '0;
      else if (fifo_wr)
         rr_ptr <= next_ptr(win_idx);
   end
`endif

   // Writes are suppressed during reset so no word is acked that the FIFO would not take.
   assign fifo_wr    = win_valid & ~fifo_full & ~rst;
   assign fifo_wdata = win_valid ? data_in[int'(win_idx)*B +: B] : data_in[B-1:0];

   always_comb begin
      ack          = '0;
      ack[win_idx] = fifo_wr;
   end

   assign wr_acc = fifo_wr & ~fifo_full;
   assign rd_acc = fifo_rd & ~fifo_empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         level <= '0;
      else if (wr_acc && !rd_acc && level != (W + 1)'(DEPTH))
         level <= level + 1'b1;
      else if (rd_acc && !wr_acc && level != '0)
         level <= level - 1'b1;
   end

   assign almost_full = (level >= (W + 1)'(DEPTH - AF_MARGIN));

endmodule

// File: tb/tb_sync_fifo_wr_arbiter.sv
// tb/tb_sync_fifo_wr_arbiter.sv - directed self-checking bench for sync_fifo_wr_arbiter.
// Expected sequences follow the build: define FIFO_ARB_BURST_EN to check the burst variant.
module tb_sync_fifo_wr_arbiter;

   localparam int N = 4;
   localparam int B = 16;
   localparam int W = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req;
   logic [N*B-1:0] data_in;
   logic [N-1:0]   ack;
   logic           fifo_wr;
   logic [B-1:0]   fifo_wdata;
   logic           fifo_full;
   logic           fifo_rd;
   logic           fifo_empty;
   logic [W:0]     level;
   logic           almost_full;

   int tests = 0;
   int fails = 0;

   logic [3:0] seq [8];
   int         idx;

   sync_fifo_wr_arbiter #(.N(N), .B(B), .W(W), .MAXBURST(4), .AF_MARGIN(2)) dut (
      .clk(clk),
      .rst(rst),
      .req(req),
      .data_in(data_in),
      .ack(ack),
      .fifo_wr(fifo_wr),
      .fifo_wdata(fifo_wdata),
      .fifo_full(fifo_full),
      .fifo_rd(fifo_rd),
      .fifo_empty(fifo_empty),
      .level(level),
      .almost_full(almost_full)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      req        = '0;
      fifo_full  = 1'b0;
      fifo_rd    = 1'b0;
      fifo_empty = 1'b1;
      #3;
      rst = 1'b0;
   endtask

   initial begin
      rst        = 1'b1;
      req        = '0;
      data_in    = '0;
      fifo_full  = 1'b0;
      fifo_rd    = 1'b0;
      fifo_empty = 1'b1;
      #3;
      check("rst_ack", 32'(ack), 32'h0);
      check("rst_wr", 32'(fifo_wr), 32'h0);
      check("rst_level", 32'(level), 32'h0);
      check("rst_af", 32'(almost_full), 32'h0);
      #9;
      rst = 1'b0;

      // read from an empty mirror must not underflow
      fifo_rd    = 1'b1;
      fifo_empty = 1'b0;
      tick();
      check("lvl_underflow", 32'(level), 32'h0);
      fifo_rd    = 1'b0;
      fifo_empty = 1'b1;

      data_in = 64'h0000_cafe_0000_0000;
      req     = 4'b0100;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("single_ack", 32'(ack), 32'h4);
         check("single_data", 32'(fifo_wdata), 32'hcafe);
         tick();
      end
      req = '0;
      check("single_level", 32'(level), 32'd3);

      do_reset();
      data_in = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
      req     = 4'b1111;
      for (int c = 0; c < 8; c++) begin
`ifdef FIFO_ARB_BURST_EN
         idx = c / 4;
`else
         idx = c % 4;
`endif
         #1;
         check("fair_ack", 32'(ack), 32'(1) << idx);
         check("fair_data", 32'(fifo_wdata), 32'h1000 + 32'(idx));
         tick();
      end
      req = '0;
      check("fair_level", 32'(level), 32'd8);

      do_reset();
      req = 4'b0001;
      for (int k = 1; k <= 16; k++) begin
         tick();
         check("fill_level", 32'(level), 32'(k));
         check("fill_af", 32'(almost_full), (k >= 14) ? 32'h1 : 32'h0);
      end
      fifo_full = 1'b1;
      req       = 4'b0011;
      for (int i = 0; i < 2; i++) begin
         #1;
         check("full_wr", 32'(fifo_wr), 32'h0);
         check("full_ack", 32'(ack), 32'h0);
         tick();
         check("full_level", 32'(level), 32'd16);
      end
      fifo_rd    = 1'b1;
      fifo_empty = 1'b0;
      tick();
      check("full_rd_level", 32'(level), 32'd15);
      fifo_rd   = 1'b0;
      fifo_full = 1'b0;
      #1;
      check("full_resume_ack", 32'(ack), 32'h2);
      check("full_resume_data", 32'(fifo_wdata), 32'h1001);
      tick();
      check("full_refill_level", 32'(level), 32'd16);
      req = '0;

      do_reset();
      req = 4'b0001;
      repeat (5) tick();
      check("rw_pre_level", 32'(level), 32'd5);
      fifo_rd    = 1'b1;
      fifo_empty = 1'b0;
      #1;
      check("rw_ack", 32'(ack), 32'h1);
      tick();
      check("rw_level", 32'(level), 32'd5);
      req        = '0;
      fifo_empty = 1'b1;
      tick();
      check("rd_empty_level", 32'(level), 32'd5);
      fifo_empty = 1'b0;
      tick();
      check("rd_level", 32'(level), 32'd4);
      fifo_rd = 1'b0;

      do_reset();
`ifdef FIFO_ARB_BURST_EN
      seq = '{4'h1, 4'h1, 4'h0, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2};
`else
      seq = '{4'h1, 4'h2, 4'h0, 4'h1, 4'h2, 4'h1, 4'h2, 4'h1};
`endif
      req = 4'b0011;
      for (int c = 0; c < 8; c++) begin
         fifo_full = (c == 2);
         #1;
         check("stall_ack", 32'(ack), 32'(seq[c]));
         tick();
      end
      fifo_full = 1'b0;
      rst = 1'b1;
      #1;
      check("midrst_wr", 32'(fifo_wr), 32'h0);
      check("midrst_ack", 32'(ack), 32'h0);
      #2;
      rst = 1'b0;
      #1;
      check("postrst_ack", 32'(ack), 32'h1);
      check("postrst_level", 32'(level), 32'h0);
      req = '0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sync_fifo_wr_arbiter.md
Name: sync_fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the synchronous FIFO between N producers.
- Picks one requesting producer per cycle and drives the FIFO write enable and write data with that producer's word.
- Returns a one-hot acknowledge to the producer whose word was written.
- Keeps a mirrored occupancy count of the FIFO so upstream logic gets level and almost-full without reaching into the FIFO.

Parameters:
- N, 4, number of producers (2..8).
- B, 16, data word width; must equal the FIFO data width.
- W, 4, FIFO address width; FIFO depth is 2**W.
- MAXBURST, 4, maximum consecutive words granted to one owner (burst build only, 1..15).
- AF_MARGIN, 2, almost_full asserts when level >= 2**W - AF_MARGIN.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- req  in  N  per-producer request; bit i high means data_in slice i holds a valid word.
- data_in  in  N*B  producer words; producer i uses bits [i*B +: B].
- ack  out  N  one-hot; bit i high means producer i's word is written at this posedge.
- fifo_wr  out  1  FIFO write enable.
- fifo_wdata  out  B  FIFO write data.
- fifo_full  in  1  FIFO full flag.
- fifo_rd  in  1  FIFO read enable issued by the consumer (monitored only).
- fifo_empty  in  1  FIFO empty flag.
- level  out  W+1  mirrored FIFO occupancy, 0..2**W.
- almost_full  out  1  level >= 2**W - AF_MARGIN.

Behaviour:
- Reset (async, rst=1):
  - rr_ptr=0, state=IDLE, owner=0, burst_cnt=0, level=0.
  - ack=0, fifo_wr=0, almost_full=0. fifo_wdata is don't-care.
- Zero-latency grant path:
  - Winner is selected combinationally in the same cycle as req.
  - fifo_wr = winner_valid & ~fifo_full.
  - ack = onehot(winner) & {N{fifo_wr}}.
  - fifo_wdata = data_in slice of the winner, or slice 0 when there is no winner.
- Handshake: a word transfers at a posedge when ack[i]=1 at that edge. The producer holds req and data stable until ack; it may drop req before ack.
- Full: fifo_wr is never asserted while fifo_full=1. No ack is given and no state advances except level.
- Round-robin: search order is rr_ptr, rr_ptr+1, ... mod N; the first set req bit wins.
- After a transfer from producer i (non-burst build), rr_ptr <= (i+1) mod N. rr_ptr is unchanged in cycles with no transfer.
- Level mirror:
  - wr_acc = fifo_wr & ~fifo_full; rd_acc = fifo_rd & ~fifo_empty.
  - level +1 on wr_acc only, -1 on rd_acc only, unchanged when both or neither occur.
  - level never exceeds 2**W and never goes below 0.
- reset mid-transfer: all state returns to reset values immediately. A word whose ack was not sampled at a posedge is not written.

Optional Feature:
- Macro: FIFO_ARB_BURST_EN.
- With the macro defined, a two-state FSM (IDLE, BURST) plus a 4-bit burst_cnt is added.
- IDLE:
  - Round-robin winner w transfers: owner <= w, burst_cnt <= 1.
  - Goes to BURST if MAXBURST > 1; otherwise rr_ptr <= w+1 and stays in IDLE.
- BURST:
  - Only owner can win; other req bits are ignored.
  - Transfer occurs: burst_cnt++. On reaching MAXBURST, rr_ptr <= owner+1 and go to IDLE.
  - req[owner]=0: no transfer this cycle; rr_ptr <= owner+1 and go to IDLE.
  - fifo_full=1 with req[owner]=1: stall; ownership and burst_cnt are held.
- Without the macro: pure per-word round-robin, no FSM or burst_cnt logic, MAXBURST ignored.

Test Plan:
- Reset then idle: rst high for 10 ns, req=0 → ack=0, fifo_wr=0, level=0, almost_full=0.
- Single producer: req=4'b0100, data_in slice 2 = 16'hcafe for 3 cycles, no reads → ack=4'b0100 each cycle, fifo_wdata=16'hcafe, level=3.
- Fairness (non-burst): req=4'b1111 held 8 cycles, fifo not full → ack sequence 0001,0010,0100,1000 repeated twice; level=8.
- Full boundary: fill to level=16 with fifo_full=1 and req=4'b0011 → fifo_wr=0, ack=0, rr_ptr held. One fifo_rd then clears full → next ack goes to the pointer's producer; level goes 16→15→16.
- Simultaneous read/write at level=5: one accepted write plus fifo_rd=1 with fifo_empty=0 → level stays 5. Read with fifo_empty=1 → level is not decremented.
- Burst (FIFO_ARB_BURST_EN, MAXBURST=4): req=4'b0011 held → ack 0001 x4, then 0010 x4. With fifo_full pulsed mid-burst, the owner is retained and burst_cnt frozen. rst mid-burst → state=IDLE, rr_ptr=0.
